// File: rtl/piano_pkg.sv
// ---------------------------------------------------------------------------
// piano_pkg
// Shared types and helpers for the Piano Tiles key-judging stage.
//   LANES         : number of key lanes (one per KEY button)
//   game_state_t  : IDLE / PLAY / OVER, encoded as rendered by the display
//   bcd_digit_t   : one packed BCD digit
//   bcd_inc_sat   : +1 on a four-digit BCD value, saturating at 9999
// ---------------------------------------------------------------------------
package piano_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Ripple the +1 through the digits; a digit at 9 wraps to 0 and carries on.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    bcd_digit_t  digit;
    result = value;
    if (value == 16'h9999) begin
      carry = 1'b0;
    end else begin
      carry = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      digit = result[i*4 +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          result[i*4 +: 4] = 4'd0;
        end else begin
          result[i*4 +: 4] = digit + 4'd1;
          carry            = 1'b0;
        end
      end else begin
        result[i*4 +: 4] = digit;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/piano_key_judge_if.sv
// ---------------------------------------------------------------------------
// piano_key_judge_if
// Tile handshake and judge results between the tile scheduler (master) and
// the key judge (slave).
//   tile_valid/tile_lane/tile_expire : hit-zone tile info, driven by master
//   tile_consume                     : judge retires the hit-zone tile
//   hit/miss                         : one-cycle judgement pulses
//   score_bcd/misses/game_state      : persistent game status for display
// ---------------------------------------------------------------------------
interface piano_key_judge_if;
  import piano_pkg::*;

  logic        tile_valid;
  logic [1:0]  tile_lane;
  logic        tile_expire;
  logic        tile_consume;
  logic        hit;
  logic        miss;
  logic [15:0] score_bcd;
  logic [1:0]  misses;
  game_state_t game_state;

  modport master (
    output tile_valid, tile_lane, tile_expire,
    input  tile_consume, hit, miss, score_bcd, misses, game_state
  );

  modport slave (
    input  tile_valid, tile_lane, tile_expire,
    output tile_consume, hit, miss, score_bcd, misses, game_state
  );

endinterface

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// One key lane: 2-flop synchronizer, stability counter and press-edge pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_n       : raw button level, 0 = pressed
//   press_edge  : one-cycle pulse on the released->pressed debounced flip
// ---------------------------------------------------------------------------
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_edge
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_s;
  logic          deb_r;
  logic [CW-1:0] cnt_r;
  logic          edge_r;

  assign level_s    = ~sync2_r;
  assign press_edge = edge_r;

  // Synchronizer; reset value models a released key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // The counter must sit at CNT_MAX with the level still differing before
  // the debounced level flips, so the flip lands DEBOUNCE_CYCLES after the
  // synchronized level first differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r  <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      edge_r <= 1'b0;
    end else begin
      edge_r <= 1'b0;
      if (level_s != deb_r) begin
        if (cnt_r == CNT_MAX) begin
          deb_r  <= level_s;
          cnt_r  <= {CW{1'b0}};
          edge_r <= level_s;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

endmodule

// File: rtl/piano_key_judge.sv
// ---------------------------------------------------------------------------
// piano_key_judge
// Debounces the four KEY buttons and judges each press against the tile in
// the hit zone; keeps BCD score, miss count and game state.
//   CLOCK_50 : 50 MHz clock
//   resetn   : asynchronous active-low reset (SW[0])
//   key_n    : raw KEY[3:0], 0 = pressed, bit i = lane i
//   bus      : tile handshake and judge results (slave side)
// ---------------------------------------------------------------------------
module piano_key_judge
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_MISSES      = 3
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [LANES-1:0] key_n,
  piano_key_judge_if.slave bus
);

  localparam logic [1:0] MISS_LAST = 2'(MAX_MISSES - 1);

  logic [LANES-1:0] edge_s;
  logic             press_any_s;
  logic             lane_hit_s;

  game_state_t      state_r;
  logic [15:0]      score_r;
  logic [1:0]       misses_r;
  logic             hit_r;
  logic             miss_r;
  logic             consume_r;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .key_n     (key_n[g]),
      .press_edge(edge_s[g])
    );
  end

  assign press_any_s = |edge_s;
  assign lane_hit_s  = bus.tile_valid & edge_s[bus.tile_lane];

  assign bus.hit          = hit_r;
  assign bus.miss         = miss_r;
  assign bus.tile_consume = consume_r;
  assign bus.score_bcd    = score_r;
  assign bus.misses       = misses_r;
  assign bus.game_state   = state_r;

  // Judge FSM with score, miss count and pulse outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      score_r   <= 16'h0000;
      misses_r  <= 2'd0;
      hit_r     <= 1'b0;
      miss_r    <= 1'b0;
      consume_r <= 1'b0;
    end else begin
      hit_r     <= 1'b0;
      miss_r    <= 1'b0;
      consume_r <= 1'b0;
      case (state_r)
        IDLE: begin
          score_r  <= 16'h0000;
          misses_r <= 2'd0;
          // The starting press only arms the game; it is not judged.
          if (press_any_s) begin
            state_r <= PLAY;
          end else begin
            state_r <= IDLE;
          end
        end
        PLAY: begin
          // A correct press wins over wrong presses and a coincident expiry.
          if (lane_hit_s) begin
            hit_r     <= 1'b1;
            consume_r <= 1'b1;
            score_r   <= bcd_inc_sat(score_r);
          end else if (press_any_s || bus.tile_expire) begin
            miss_r   <= 1'b1;
            misses_r <= misses_r + 2'd1;
            if (misses_r == MISS_LAST) begin
              state_r <= OVER;
            end else begin
              state_r <= PLAY;
            end
          end else begin
            state_r <= PLAY;
          end
        end
        OVER: begin
          if (press_any_s) begin
            state_r  <= IDLE;
            score_r  <= 16'h0000;
            misses_r <= 2'd0;
          end else begin
            state_r <= OVER;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/piano_key_judge.md
# piano_key_judge

Input-judging stage directly upstream of `display` in the Piano Tiles design. It debounces the four raw `KEY` buttons and compares each press against the tile currently in the hit zone. It issues hit, miss and tile-consume pulses, and keeps the BCD score, miss count and game state that `display` renders to VGA and HEX.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a key level (10 ms at 50 MHz).
- `MAX_MISSES`, 3: miss count at which the game ends (1..3).
- `CLOCK_50  in  1`: single clock, 50 MHz.
- `resetn  in  1`: reset, asynchronous, active-low. Driven from `SW[0]`.
- `key_n  in  4`: raw `KEY[3:0]`, asynchronous, 0 = pressed. Bit i = lane i.
- `tile_valid  in  1`: a tile occupies the hit zone.
- `tile_lane  in  2`: lane of that tile. Meaningful only when `tile_valid` = 1.
- `tile_expire  in  1`: 1-cycle pulse. The hit-zone tile left the zone unconsumed.
- `tile_consume  out  1`: 1-cycle pulse. Upstream retires the hit-zone tile.
- `hit  out  1`: 1-cycle pulse, correct press.
- `miss  out  1`: 1-cycle pulse, wrong press or expiry.
- `score_bcd  out  16`: four BCD digits, [15:12] most significant.
- `misses  out  2`: current miss count.
- `game_state  out  2`: 0 IDLE, 1 PLAY, 2 OVER.

## Operation
- **Reset values:** all outputs 0; `game_state` = IDLE; all debounced keys released; debounce counters 0.
- **Key input path:**
  - Each `key_n` bit passes through a 2-flop synchronizer.
  - Per lane, a counter increments while the synchronized level differs from the debounced level, and clears otherwise.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A press edge is an internal 1-cycle pulse on the released→pressed flip. Release edges are ignored.
- **IDLE:** score and misses held at 0. Any press edge → PLAY. That press is not judged.
- **PLAY:** evaluate each cycle, in order:
  - Any press edge with `tile_valid` = 1 and bit `tile_lane` among the edges → `hit` and `tile_consume`. Score +1. Other simultaneous edges are ignored.
  - Otherwise, any press edge → `miss`. There is no consume on a wrong press; the tile stays.
  - Otherwise, `tile_expire` → `miss`.
  - At most one `hit` or `miss` per cycle. `hit` and `miss` are never both asserted.
  - A cycle that produces a hit ignores a coincident `tile_expire`.
- **Miss handling:** `misses` increments on every `miss`. When it reaches `MAX_MISSES`, go to OVER on the same edge that asserts that `miss`.
- **OVER:** score and misses frozen. Inputs are not judged. Any press edge → IDLE, clearing score and misses on entry.
- **Score arithmetic:**
  - BCD increment with per-digit carry: 0009→0010, 0099→0100.
  - Saturates at 9999. A hit at 9999 still pulses `hit` and `tile_consume`.
- **Reset mid-operation:** an asserted `resetn` = 0 immediately forces the reset values, including pulses in flight. Partial debounce counts are discarded.

## Timing
- `hit`, `miss`, `tile_consume`, `score_bcd`, `misses` and `game_state` are all registered and update on the same clock edge.
- **Key latency:** `key_n[i]` low from cycle 0 (sampled at edge 0):
  - synchronized level visible at cycle 2;
  - debounced flip and press edge at cycle 2 + `DEBOUNCE_CYCLES`;
  - `hit`/`miss` high during cycle 3 + `DEBOUNCE_CYCLES`.
- **Expiry latency:** `tile_expire` sampled at edge N → `miss` high in cycle N+1.
- **Upstream obligations:**
  - Hold `tile_valid` and `tile_lane` stable until `tile_consume` or `tile_expire`.
  - Drop `tile_valid`, or advance to the next tile, the cycle after `tile_consume`.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no edge.

## Structure
- Package `piano_pkg`:
  - `game_state_t` enum (IDLE, PLAY, OVER);
  - `LANES` = 4;
  - BCD digit type;
  - function `bcd_inc_sat` on 16-bit BCD.
- Sub-module `key_debouncer`: one lane; synchronizer, counter, debounced level and press-edge output, parameterized by `DEBOUNCE_CYCLES`. Instantiated four times.
- Top holds the judge FSM, score and miss registers.

## Test plan
The bench uses `DEBOUNCE_CYCLES` = 8.
- **Reset:** hold `resetn` = 0 while toggling `key_n` → all outputs 0 and `game_state` = 0 throughout. Release reset → still IDLE.
- **Glitch and start:** 5-cycle low glitch on `key_n[0]` → no edge, stays IDLE. Hold `key_n[0]` low → PLAY exactly 11 cycles after the first low sample, with no `hit`/`miss`.
- **Hit:** in PLAY with `tile_valid` = 1, `tile_lane` = 2, press `key_n[2]` → `hit` = 1 and `tile_consume` = 1 for one cycle, `score_bcd` 0000→0001. Repeat nine more hits → 0010.
- **Wrong lane and simultaneous expiry:** press lane 1 while tile is in lane 3 → `miss` = 1, no `tile_consume`, `misses` = 1. Press lane 3 in the same cycle as `tile_expire` → `hit` only, `misses` unchanged.
- **Game over and restart:** three `tile_expire` pulses → `misses` = 3, `game_state` = 2 on the third. Further expiries leave `misses` unchanged. A press → IDLE with score 0000 and `misses` 0.
- **Saturation and reset:** preload to 9999 via hits, then hit again → score stays 9999 and `hit` still pulses. Assert `resetn` mid-press → outputs cleared, and no edge appears after release.
